// File: rtl/ece453_gpio_irq.sv
// Avalon-MM GPIO block: synchronised and debounced inputs with edge-triggered, maskable,
// write-1-to-clear interrupts, plus a bank of directly driven outputs.
module ece453_gpio_irq #(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned SAMPLE_CYCLES  = 500000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic [3:0]        slave_byteenable,
  output logic [31:0]       slave_readdata,
  input  logic [NUM_CH-1:0] gpio_inputs,
  output logic [NUM_CH-1:0] gpio_outputs,
  output logic              irq_out
);

  localparam logic [31:0] DEV_ID    = 32'hECE4_5320;
  localparam logic [23:0] RELOAD    = 24'(SAMPLE_CYCLES - 1);
  localparam logic [2:0]  AGREE_MAX = 3'(STABLE_SAMPLES - 1);

  typedef enum logic [4:0] {
    A_DEV_ID  = 5'd0,
    A_CONTROL = 5'd1,
    A_STATUS  = 5'd2,
    A_IM      = 5'd3,
    A_IRQ     = 5'd4,
    A_RISE_EN = 5'd5,
    A_FALL_EN = 5'd6,
    A_GPIO    = 5'd7,
    A_RAW_IN  = 5'd8
  } addr_e;

  logic                   ctrl_en_q, ctrl_en_d;
  logic                   sample_now_q, sample_now_d;
  logic [23:0]            cnt_q;
  logic                   tick;
  logic [NUM_CH-1:0]      in_meta_q, in_sync_q;
  logic [NUM_CH-1:0]      level_q, level_d, prev_level_q;
  logic [NUM_CH-1:0][2:0] agree_q, agree_d;
  logic [NUM_CH-1:0]      im_q, im_d, irq_q, irq_d;
  logic [NUM_CH-1:0]      rise_q, rise_d, fall_q, fall_d, out_q, out_d;
  logic [NUM_CH-1:0]      ch_mask, ch_wdata, w1c, set_ev;

  function automatic logic [NUM_CH-1:0] merge(input logic [NUM_CH-1:0] old_v,
                                              input logic [NUM_CH-1:0] new_v,
                                              input logic [NUM_CH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // A tick comes from the free-running counter or from a software sample-now request.
  assign tick = sample_now_q | (ctrl_en_q & (cnt_q == 24'd0));

  // Edge events are detected one cycle after the debounced level flips.
  assign set_ev = (level_q & ~prev_level_q & rise_q) | (~level_q & prev_level_q & fall_q);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    level_d = level_q;
    agree_d = agree_q;
    if (tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_sync_q[i] != level_q[i]) begin
          if (agree_q[i] == AGREE_MAX) begin
            level_d[i] = ~level_q[i];
            agree_d[i] = 3'd0;
          end else begin
            agree_d[i] = agree_q[i] + 3'd1;
          end
        end else begin
          agree_d[i] = 3'd0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_mask[i] = slave_byteenable[i/8];
    ch_wdata     = slave_writedata[NUM_CH-1:0];
    ctrl_en_d    = ctrl_en_q;
    sample_now_d = 1'b0;
    im_d         = im_q;
    rise_d       = rise_q;
    fall_d       = fall_q;
    out_d        = out_q;
    w1c          = '0;
    if (slave_write) begin
      case (slave_address)
        A_CONTROL: if (slave_byteenable[0]) begin
          ctrl_en_d    = slave_writedata[0];
          sample_now_d = slave_writedata[1];
        end
        A_IM:      im_d   = merge(im_q, ch_wdata, ch_mask);
        A_IRQ:     w1c    = ch_wdata & ch_mask;
        A_RISE_EN: rise_d = merge(rise_q, ch_wdata, ch_mask);
        A_FALL_EN: fall_d = merge(fall_q, ch_wdata, ch_mask);
        A_GPIO:    out_d  = merge(out_q, ch_wdata, ch_mask);
        default: ;
      endcase
    end
    // A new event wins over a simultaneous clear.
    irq_d = (irq_q & ~w1c) | set_ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en_q    <= 1'b0;
      sample_now_q <= 1'b0;
      cnt_q        <= RELOAD;
      in_meta_q    <= '0;
      in_sync_q    <= '0;
      level_q      <= '0;
      prev_level_q <= '0;
      agree_q      <= '0;
      im_q         <= '0;
      irq_q        <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      out_q        <= '0;
    end else begin
      ctrl_en_q    <= ctrl_en_d;
      sample_now_q <= sample_now_d;
      if (tick)           cnt_q <= RELOAD;
      else if (ctrl_en_q) cnt_q <= cnt_q - 24'd1;
      in_meta_q    <= gpio_inputs;
      in_sync_q    <= in_meta_q;
      level_q      <= level_d;
      prev_level_q <= level_q;
      agree_q      <= agree_d;
      im_q         <= im_d;
      irq_q        <= irq_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      out_q        <= out_d;
    end
  end

  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        A_DEV_ID:  slave_readdata = DEV_ID;
        A_CONTROL: slave_readdata = {31'd0, ctrl_en_q};
        A_STATUS:  slave_readdata = 32'(level_q);
        A_IM:      slave_readdata = 32'(im_q);
        A_IRQ:     slave_readdata = 32'(irq_q);
        A_RISE_EN: slave_readdata = 32'(rise_q);
        A_FALL_EN: slave_readdata = 32'(fall_q);
        A_GPIO:    slave_readdata = 32'(out_q);
        A_RAW_IN:  slave_readdata = 32'(in_sync_q);
        default: ;
      endcase
    end
  end

  assign gpio_outputs = out_q;
  assign irq_out      = |(im_q & irq_q);

endmodule

// File: doc/ece453_gpio_irq.md
ECE453_GPIO_IRQ -- requirements
Module: ece453_gpio_irq

Interface
REQ-001 Parameter NUM_CH, default 8, number of GPIO input/output channels; legal range 1..32.
REQ-002 Parameter SAMPLE_CYCLES, default 500000, clock cycles between debounce sample ticks; legal range 2..2^24-1.
REQ-003 Parameter STABLE_SAMPLES, default 4, consecutive identical samples required to change a debounced level; legal range 2..8.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 slave_address  input  5  Avalon-MM word address.
REQ-007 slave_read  input  1  read strobe.
REQ-008 slave_write  input  1  write strobe.
REQ-009 slave_writedata  input  32  write data.
REQ-010 slave_byteenable  input  4  per-byte write enable.
REQ-011 slave_readdata  output  32  read data.
REQ-012 gpio_inputs  input  NUM_CH  raw asynchronous inputs (switches/buttons).
REQ-013 gpio_outputs  output  NUM_CH  driven outputs.
REQ-014 irq_out  output  1  level interrupt request.

Function
REQ-015 Register map (word addresses): 0 DEV_ID RO 0xECE45320; 1 CONTROL RW (bit0 enable, bit1 sample-now); 2 STATUS RO (debounced levels); 3 IM RW; 4 IRQ R/W1C; 5 RISE_EN RW; 6 FALL_EN RW; 7 GPIO_OUT RW; 8 RAW_IN RO (synchronised inputs).
REQ-016 slave_readdata combinational: selected register when slave_read=1 and address mapped, else 0; bits at or above NUM_CH read 0 for channel-wide registers.
REQ-017 Writes take effect on the clock edge with slave_write=1; only bytes with slave_byteenable bit set are updated; writes to RO or unmapped addresses are ignored.
REQ-018 Each gpio_inputs bit passes through a 2-flop synchroniser before any use.
REQ-019 A free-running 24-bit down-counter reloads SAMPLE_CYCLES-1 at zero; the zero cycle is one sample tick; counter runs only while CONTROL.enable=1 and holds its value otherwise.
REQ-020 CONTROL.bit1 written 1 produces one sample tick on the next cycle and reloads the counter; the bit is self-clearing and reads 0.
REQ-021 Per channel, on each tick: a synchronised sample differing from the debounced level increments a 3-bit agree counter, else clears it; when the counter reaches STABLE_SAMPLES-1 and the sample still differs, the debounced level flips and the counter clears.
REQ-022 A 0->1 debounced transition with RISE_EN[i]=1, or 1->0 with FALL_EN[i]=1, sets IRQ[i] on the edge after the flip.
REQ-023 IRQ[i] write-1 clears; a set event and a W1C clear on the same cycle leave IRQ[i]=1.
REQ-024 irq_out = OR over (IM & IRQ), registered-source combinational, no extra latency.
REQ-025 gpio_outputs = GPIO_OUT[NUM_CH-1:0] directly.
REQ-026 CONTROL.enable=0: no ticks, debounced levels and agree counters hold; IRQ, IM and GPIO_OUT remain accessible.

Reset
REQ-027 On reset: CONTROL, IM, IRQ, RISE_EN, FALL_EN, GPIO_OUT, agree counters = 0; synchroniser flops and debounced levels = 0; counter = SAMPLE_CYCLES-1; irq_out=0, gpio_outputs=0.
REQ-028 Reset asserted mid-debounce discards partial agree counts; no IRQ set by the post-reset first sample unless STABLE_SAMPLES ticks of agreement occur.

Verification
REQ-029 Reset, read addr 0 -> 0xECE45320; read addr 9 -> 0; all outputs 0.
REQ-030 SAMPLE_CYCLES=4, STABLE_SAMPLES=4, enable=1, RISE_EN=1, IM=1, hold gpio_inputs[0]=1 -> STATUS[0]=1 and irq_out=1 after 4 ticks (~16+2 cycles), not before.
REQ-031 Input 0 glitched high for 2 ticks then low -> STATUS[0] stays 0, IRQ=0.
REQ-032 IRQ[0]=1, write IRQ=0x1 on the same cycle a new enabled edge on ch0 flips -> IRQ[0]=1; separate W1C -> IRQ[0]=0, irq_out=0.
REQ-033 Write GPIO_OUT=0xFFFFFFFF with byteenable=4'b0001, NUM_CH=8 -> gpio_outputs=0xFF, readback 0x000000FF.
REQ-034 enable=0, input toggled for 10*SAMPLE_CYCLES -> STATUS unchanged; CONTROL.bit1 pulses x4 -> STATUS follows input.
